// File: rtl/iomem_initiator.sv
// Bus-master front end for the iomem peripheral bus: one single-word read/write per
// request, bounded wait for the responder's ready pulse, result on a response port.
module iomem_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_count,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             iomem_valid_d;
  logic [31:0]      iomem_addr_d, iomem_wdata_d;
  logic [3:0]       iomem_wstrb_d;
  logic             rsp_valid_d, rsp_err_d;
  logic [31:0]      rsp_rdata_d;
  logic [7:0]       err_count_d;
  logic             expired;

  assign req_ready = (state == IDLE);
  assign expired   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      iomem_valid <= 1'b0;
      iomem_addr  <= 32'h0;
      iomem_wdata <= 32'h0;
      iomem_wstrb <= 4'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      err_count   <= 8'h0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      iomem_valid <= iomem_valid_d;
      iomem_addr  <= iomem_addr_d;
      iomem_wdata <= iomem_wdata_d;
      iomem_wstrb <= iomem_wstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      err_count   <= err_count_d;
    end
  end

  // Next-state and registered-output logic; ready beats a coincident timeout.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    iomem_valid_d = iomem_valid;
    iomem_addr_d  = iomem_addr;
    iomem_wdata_d = iomem_wdata;
    iomem_wstrb_d = iomem_wstrb;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    err_count_d   = err_count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          iomem_addr_d  = req_addr;
          iomem_wdata_d = req_wdata;
          iomem_wstrb_d = req_wstrb;
          iomem_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        if (iomem_ready) begin
          iomem_valid_d = 1'b0;
          rsp_rdata_d   = (iomem_wstrb == 4'h0) ? iomem_rdata : 32'h0;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (expired) begin
          iomem_valid_d = 1'b0;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator: behavioural responder with programmable wait,
// timeout/saturation, hold/stray-ready and asynchronous reset scenarios.
module tb_iomem_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk, resetn;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;
  logic [7:0]  err_count;
  logic        iomem_valid, iomem_ready;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic [3:0]  iomem_wstrb;

  logic        t4_req_valid, t4_req_ready, t4_rsp_valid, t4_rsp_ready, t4_rsp_err;
  logic [31:0] t4_req_addr, t4_req_wdata, t4_rsp_rdata;
  logic [3:0]  t4_req_wstrb;
  logic [7:0]  t4_err_count;
  logic        t4_iomem_valid, t4_iomem_ready;
  logic [31:0] t4_iomem_addr, t4_iomem_wdata, t4_iomem_rdata;
  logic [3:0]  t4_iomem_wstrb;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  int          rsp_delay = 1;
  bit          rsp_en = 0;
  bit          stray = 0;
  logic [31:0] rsp_data = 32'h0;
  int          vcnt = 0;

  iomem_initiator #(.TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata)
  );

  iomem_initiator #(.TIMEOUT(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .req_valid(t4_req_valid), .req_ready(t4_req_ready), .req_addr(t4_req_addr),
    .req_wdata(t4_req_wdata), .req_wstrb(t4_req_wstrb),
    .rsp_valid(t4_rsp_valid), .rsp_ready(t4_rsp_ready), .rsp_rdata(t4_rsp_rdata),
    .rsp_err(t4_rsp_err), .err_count(t4_err_count),
    .iomem_valid(t4_iomem_valid), .iomem_ready(t4_iomem_ready), .iomem_addr(t4_iomem_addr),
    .iomem_wdata(t4_iomem_wdata), .iomem_wstrb(t4_iomem_wstrb), .iomem_rdata(t4_iomem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: acks in valid cycle rsp_delay+1; junk on rdata outside the ack cycle.
  initial begin
    iomem_ready = 1'b0;
    iomem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEAD_BEEF;
        vcnt = 0;
      end else if (stray) begin
        iomem_ready = 1'b1;
        iomem_rdata = 32'h9999_9999;
        stray = 0;
      end else if (rsp_en && iomem_valid) begin
        vcnt++;
        if (vcnt == rsp_delay + 1) begin
          iomem_ready = 1'b1;
          iomem_rdata = rsp_data;
        end
      end else begin
        vcnt = 0;
      end
    end
  end

  // One command on the main instance; returns what was observed, no judging.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int vhigh, output bit stable, output bit vlow_after,
                        output bit tmo);
    int n;
    req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    tmo = 0; n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; vhigh = 0; stable = 1; n = 0;
    while (!rsp_valid && n < 200) begin
      if (iomem_valid) begin
        vhigh++;
        if (iomem_addr !== a || iomem_wdata !== wd || iomem_wstrb !== ws) stable = 0;
      end
      @(posedge clk); #1; n++; lat++;
    end
    if (!rsp_valid) tmo = 1;
    rd = rsp_rdata; er = rsp_err; vlow_after = !iomem_valid;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [111:0] outs;
    resetn = 1'b0;
    req_valid = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
    t4_req_valid = 0; t4_req_addr = 0; t4_req_wdata = 0; t4_req_wstrb = 0; t4_rsp_ready = 0;
    t4_iomem_ready = 0; t4_iomem_rdata = 0;
    repeat (3) @(posedge clk); #1;
    outs = {iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb, rsp_valid, rsp_rdata,
            rsp_err, err_count, 2'b00};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_values: got %h expected 0", outs);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_write;
    logic [31:0] rd; logic er; int lat, vh; bit st, vl, tmo; exp_t e;
    rsp_en = 1; rsp_delay = 1; rsp_data = 32'h5555_AAAA;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    do_txn(32'h0400_0000, 32'h0000_0096, 4'b0011, rd, er, lat, vh, st, vl, tmo);
    e = sb.pop_front();
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL write_tmo: no response"); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL write_rdata: got %h expected %h", rd, e.rdata); end
    n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL write_err: got %b expected %b", er, e.err); end
    n_cmp++; if (vh !== 2) begin n_bad++; $display("FAIL write_valid_cycles: got %0d expected 2", vh); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL write_stable: got %b expected 1", st); end
    n_cmp++; if (vl !== 1'b1) begin n_bad++; $display("FAIL write_valid_low_after_ready: got %b expected 1", vl); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_read;
    logic [31:0] rd; logic er; int lat, vh; bit st, vl, tmo; exp_t e;
    rsp_en = 1; rsp_delay = 5; rsp_data = 32'hABCD_0012;
    sb.push_back('{rdata: 32'hABCD_0012, err: 1'b0});
    do_txn(32'h0300_0000, 32'h1234_5678, 4'b0000, rd, er, lat, vh, st, vl, tmo);
    e = sb.pop_front();
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL read_rdata: got %h expected %h", rd, e.rdata); end
    n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL read_err: got %b expected %b", er, e.err); end
    n_cmp++; if (lat !== rsp_delay + 2) begin n_bad++; $display("FAIL read_latency: got %0d expected %0d", lat, rsp_delay + 2); end
    n_cmp++; if (vh !== rsp_delay + 1) begin n_bad++; $display("FAIL read_valid_cycles: got %0d expected %0d", vh, rsp_delay + 1); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL read_stable: got %b expected 1", st); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic er; int lat, vh; bit st, vl, tmo; exp_t e;
    rsp_en = 0;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    do_txn(32'h0200_0004, 32'h0, 4'b0000, rd, er, lat, vh, st, vl, tmo);
    e = sb.pop_front();
    n_cmp++; if (vh !== 64) begin n_bad++; $display("FAIL timeout_valid_cycles: got %0d expected 64", vh); end
    n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL timeout_err: got %b expected %b", er, e.err); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL timeout_rdata: got %h expected %h", rd, e.rdata); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL timeout_err_count: got %0d expected 1", err_count); end
    for (int i = 2; i <= 300; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      do_txn(32'h0200_0000 + 32'(i), 32'h0, 4'b0000, rd, er, lat, vh, st, vl, tmo);
      e = sb.pop_front();
      n_cmp++;
      if (er !== e.err) begin n_bad++; $display("FAIL timeout_loop_err[%0d]: got %b expected %b", i, er, e.err); end
      if (i == 254) begin
        n_cmp++;
        if (err_count !== 8'd254) begin n_bad++; $display("FAIL err_count_254: got %0d expected 254", err_count); end
      end
    end
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_count_saturate: got %0d expected 255", err_count); end
  endtask

  task automatic test_ready_on_timeout;
    logic [31:0] rd; logic er; int lat, vh; bit st, vl, tmo; exp_t e;
    rsp_en = 1; rsp_delay = 63; rsp_data = 32'h0F0F_1234;
    sb.push_back('{rdata: 32'h0F0F_1234, err: 1'b0});
    do_txn(32'h0300_0008, 32'h0, 4'b0000, rd, er, lat, vh, st, vl, tmo);
    e = sb.pop_front();
    n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL edge64_err: got %b expected %b", er, e.err); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL edge64_rdata: got %h expected %h", rd, e.rdata); end
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL edge64_err_count: got %0d expected 255", err_count); end
  endtask

  task automatic test_hold_and_stray;
    logic [31:0] hold_rd; int n; bit ok; bit tmo;
    rsp_en = 1; rsp_delay = 1; rsp_data = 32'h1111_2222;
    req_addr = 32'h0300_0010; req_wdata = 32'h0; req_wstrb = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h0400_0020; req_wdata = 32'h0000_0077; req_wstrb = 4'hF;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    tmo = !rsp_valid;
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL hold_rsp_timeout: no response"); end
    hold_rd = 32'h1111_2222;
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 6) stray = 1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== hold_rd || rsp_err !== 1'b0 ||
          req_ready !== 1'b0 || iomem_valid !== 1'b0 || err_count !== 8'd255) ok = 0;
      @(posedge clk); #1;
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hold_stable: got %b expected 1", ok); end
    n_cmp++; if (rsp_rdata !== hold_rd) begin n_bad++; $display("FAIL hold_rdata: got %h expected %h", rsp_rdata, hold_rd); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release: got req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h0400_0020) begin n_bad++; $display("FAIL second_accept: got valid=%b addr=%h expected 1/04000020", iomem_valid, iomem_addr); end
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL second_rsp: got v=%b rd=%h err=%b expected 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout4;
    int vh, n; exp_t e;
    // Ready arrives in the 4th valid cycle, the same cycle the timeout would fire.
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    t4_req_addr = 32'h0100_0000; t4_req_wstrb = 4'h0; t4_req_valid = 1'b1;
    @(posedge clk); #1;
    t4_req_valid = 1'b0;
    vh = 0;
    for (int c = 1; c <= 4; c++) begin
      if (t4_iomem_valid) vh++;
      if (c == 4) begin t4_iomem_ready = 1'b1; t4_iomem_rdata = 32'h0BAD_F00D; end
      @(posedge clk); #1;
    end
    t4_iomem_ready = 1'b0; t4_iomem_rdata = 32'h0;
    e = sb.pop_front();
    n_cmp++; if (vh !== 4) begin n_bad++; $display("FAIL t4_valid_cycles: got %0d expected 4", vh); end
    n_cmp++; if (t4_rsp_valid !== 1'b1 || t4_rsp_err !== e.err) begin n_bad++; $display("FAIL t4_tie_err: got v=%b err=%b expected 1/%b", t4_rsp_valid, t4_rsp_err, e.err); end
    n_cmp++; if (t4_rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL t4_tie_rdata: got %h expected %h", t4_rsp_rdata, e.rdata); end
    n_cmp++; if (t4_err_count !== 8'd0) begin n_bad++; $display("FAIL t4_tie_err_count: got %0d expected 0", t4_err_count); end
    t4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t4_rsp_ready = 1'b0;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    t4_req_valid = 1'b1;
    @(posedge clk); #1;
    t4_req_valid = 1'b0;
    vh = 0; n = 0;
    while (!t4_rsp_valid && n < 50) begin
      if (t4_iomem_valid) vh++;
      @(posedge clk); #1; n++;
    end
    e = sb.pop_front();
    n_cmp++; if (vh !== 4) begin n_bad++; $display("FAIL t4_timeout_cycles: got %0d expected 4", vh); end
    n_cmp++; if (t4_rsp_err !== e.err || t4_err_count !== 8'd1) begin n_bad++; $display("FAIL t4_timeout: got err=%b cnt=%0d expected %b/1", t4_rsp_err, t4_err_count, e.err); end
    t4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t4_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] rd; logic er; int lat, vh; bit st, vl, tmo, quiet; exp_t e;
    rsp_en = 0;
    req_addr = 32'h0200_0100; req_wdata = 32'h0; req_wstrb = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (iomem_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b expected 1", iomem_valid); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin n_bad++; $display("FAIL async_reset: got v=%b rv=%b cnt=%0d expected 0/0/0", iomem_valid, rsp_valid, err_count); end
    @(posedge clk); #1;
    resetn = 1'b1;
    quiet = 1;
    repeat (80) begin
      if (rsp_valid !== 1'b0 || iomem_valid !== 1'b0) quiet = 0;
      @(posedge clk); #1;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL dropped_no_response: got %b expected 1", quiet); end
    rsp_en = 1; rsp_delay = 2; rsp_data = 32'hC0DE_0042;
    sb.push_back('{rdata: 32'hC0DE_0042, err: 1'b0});
    do_txn(32'h0300_0004, 32'h0, 4'b0000, rd, er, lat, vh, st, vl, tmo);
    e = sb.pop_front();
    n_cmp++; if (rd !== e.rdata || er !== e.err) begin n_bad++; $display("FAIL post_reset_txn: got rd=%h err=%b expected %h/%b", rd, er, e.rdata, e.err); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL post_reset_latency: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ready_on_timeout();
    test_hold_and_stray();
    test_timeout4();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
